// File: rtl/mem_wait_ctrl4510_if.sv
// ---------------------------------------------------------------------------
// mem_wait_ctrl4510_if
// Bundles the CPU/mapper request side and the memory-bus side of the 4510
// bus-cycle stage.
//   Request (master -> slave): phi2, address_next[19:0], map_next, we,
//                              io_en, exp_ack
//   Bus     (slave -> master): bus_addr[19:0], bus_we, cs_ram, cs_rom,
//                              cs_io, cs_exp, ready, bus_error,
//                              wait_count[3:0]
// ---------------------------------------------------------------------------
interface mem_wait_ctrl4510_if;
    logic        phi2;
    logic [19:0] address_next;
    logic        map_next;
    logic        we;
    logic        io_en;
    logic        exp_ack;

    logic [19:0] bus_addr;
    logic        bus_we;
    logic        cs_ram;
    logic        cs_rom;
    logic        cs_io;
    logic        cs_exp;
    logic        ready;
    logic        bus_error;
    logic [3:0]  wait_count;

    modport master (
        output phi2, address_next, map_next, we, io_en, exp_ack,
        input  bus_addr, bus_we, cs_ram, cs_rom, cs_io, cs_exp,
               ready, bus_error, wait_count
    );

    modport slave (
        input  phi2, address_next, map_next, we, io_en, exp_ack,
        output bus_addr, bus_we, cs_ram, cs_rom, cs_io, cs_exp,
               ready, bus_error, wait_count
    );
endinterface

// File: rtl/mem_wait_ctrl4510.sv
// ---------------------------------------------------------------------------
// mem_wait_ctrl4510
// Bus-cycle stage behind the 4510 mapper. On a phi2-qualified clock edge
// while idle it latches the physical address and write strobe, decodes a
// one-hot chip select, and stalls the CPU (ready=0) for a per-region number
// of wait states. Expansion cycles instead wait for exp_ack, giving up after
// EXP_TIMEOUT cycles with a one-cycle bus_error pulse.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - request/bus signal bundle (slave modport)
// ---------------------------------------------------------------------------
module mem_wait_ctrl4510 #(
    parameter int unsigned RAM_WAIT    = 0,
    parameter int unsigned ROM_WAIT    = 1,
    parameter int unsigned IO_WAIT     = 2,
    parameter int unsigned EXP_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_wait_ctrl4510_if.slave   bus
);

    localparam logic [3:0] RAM_N = 4'(RAM_WAIT);
    localparam logic [3:0] ROM_N = 4'(ROM_WAIT);
    localparam logic [3:0] IO_N  = 4'(IO_WAIT);
    localparam logic [3:0] EXP_N = 4'(EXP_TIMEOUT);

    // One-hot chip-select bit positions
    localparam int CS_RAM = 0;
    localparam int CS_ROM = 1;
    localparam int CS_IO  = 2;
    localparam int CS_EXP = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXT  = 2'd2
    } state_t;

    // Region decode; the I/O window only exists for untranslated addresses
    // and takes priority over the RAM range it overlaps.
    function automatic logic [3:0] decode_cs(input logic [19:0] addr,
                                             input logic        map_flag,
                                             input logic        io_enable);
        logic [3:0] cs;
        cs = 4'b0000;
        if (!map_flag && io_enable && (addr[19:16] == 4'h0) && (addr[15:12] == 4'hD)) begin
            cs[CS_IO] = 1'b1;
        end else if (addr[19:17] == 3'd0) begin
            cs[CS_RAM] = 1'b1;
        end else if (addr[19:17] == 3'd1) begin
            cs[CS_ROM] = 1'b1;
        end else begin
            cs[CS_EXP] = 1'b1;
        end
        return cs;
    endfunction

    state_t      state_q,      state_d;
    logic        ready_q,      ready_d;
    logic [19:0] bus_addr_q,   bus_addr_d;
    logic        bus_we_q,     bus_we_d;
    logic [3:0]  cs_q,         cs_d;
    logic        bus_error_q,  bus_error_d;
    logic [3:0]  wait_count_q, wait_count_d;

    logic [3:0]  cap_cs_s;
    logic [3:0]  cap_wait_s;

    // Decode the incoming request and pick its fixed wait-state count
    always_comb begin
        cap_cs_s   = decode_cs(bus.address_next, bus.map_next, bus.io_en);
        cap_wait_s = 4'd0;
        case (cap_cs_s)
            4'b0001: cap_wait_s = RAM_N;
            4'b0010: cap_wait_s = ROM_N;
            4'b0100: cap_wait_s = IO_N;
            4'b1000: cap_wait_s = EXP_N;
            default: cap_wait_s = 4'd0;
        endcase
    end

    // Next-state and output logic for the bus-cycle FSM
    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        bus_addr_d   = bus_addr_q;
        bus_we_d     = bus_we_q;
        cs_d         = cs_q;
        bus_error_d  = 1'b0;
        wait_count_d = wait_count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.phi2) begin
                    bus_addr_d = bus.address_next;
                    bus_we_d   = bus.we;
                    cs_d       = cap_cs_s;
                    if (cap_cs_s[CS_EXP]) begin
                        ready_d      = 1'b0;
                        wait_count_d = cap_wait_s;
                        state_d      = ST_EXT;
                    end else if (cap_wait_s != 4'd0) begin
                        ready_d      = 1'b0;
                        wait_count_d = cap_wait_s;
                        state_d      = ST_WAIT;
                    end else begin
                        ready_d      = 1'b1;
                        wait_count_d = 4'd0;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end

            ST_WAIT: begin
                // <=1 rather than ==1 so a zero count can never wrap
                if (wait_count_q <= 4'd1) begin
                    wait_count_d = 4'd0;
                    ready_d      = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    wait_count_d = wait_count_q - 4'd1;
                end
            end

            ST_EXT: begin
                // Acknowledge is checked first so it wins on the timeout edge
                if (bus.exp_ack) begin
                    wait_count_d = 4'd0;
                    ready_d      = 1'b1;
                    state_d      = ST_IDLE;
                end else if (wait_count_q <= 4'd1) begin
                    bus_error_d  = 1'b1;
                    wait_count_d = 4'd0;
                    ready_d      = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    wait_count_d = wait_count_q - 4'd1;
                end
            end

            default: begin
                wait_count_d = 4'd0;
                ready_d      = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and registered bus outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            bus_addr_q   <= 20'h00000;
            bus_we_q     <= 1'b0;
            cs_q         <= 4'b0000;
            bus_error_q  <= 1'b0;
            wait_count_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            bus_addr_q   <= bus_addr_d;
            bus_we_q     <= bus_we_d;
            cs_q         <= cs_d;
            bus_error_q  <= bus_error_d;
            wait_count_q <= wait_count_d;
        end
    end

    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_we     = bus_we_q;
    assign bus.cs_ram     = cs_q[CS_RAM];
    assign bus.cs_rom     = cs_q[CS_ROM];
    assign bus.cs_io      = cs_q[CS_IO];
    assign bus.cs_exp     = cs_q[CS_EXP];
    assign bus.ready      = ready_q;
    assign bus.bus_error  = bus_error_q;
    assign bus.wait_count = wait_count_q;

endmodule
